// File: rtl/mspe_pkg.sv
// -----------------------------------------------------------------------------
// mspe_pkg: shared types and helpers for the egress arbiter | Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

package mspe_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_e;

  localparam int PKT_CNT_W = 32;

  // Channel index width; a single-channel build still carries a 1-bit index.
  function automatic int ch_w(input int cores);
    return (cores <= 1) ? 1 : $clog2(cores);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mspe_rr_pick.sv
// -----------------------------------------------------------------------------
// mspe_rr_pick: combinational round-robin / fixed-priority request picker | Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module mspe_rr_pick
  import mspe_pkg::*;
#(
  parameter int CORES = 4,
  parameter int IDX_W = ch_w(CORES)
) (
  input  logic [CORES-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  input  logic             mode,
  output logic [IDX_W-1:0] gnt,
  output logic             any
);

  // Scan downward so the lowest index (or smallest offset from ptr) wins last.
  always_comb begin
    gnt = '0;
    any = |req;
    for (int k = CORES - 1; k >= 0; k--) begin
      if (mode) begin
        if (req[k]) gnt = IDX_W'(k);
      end else if (req[(int'(ptr) + k) % CORES]) begin
        gnt = IDX_W'((int'(ptr) + k) % CORES);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/mspe_egress_arb.sv
// -----------------------------------------------------------------------------
// mspe_egress_arb: per-core packet arbiter streaming whole packets to the source port | Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module mspe_egress_arb
  import mspe_pkg::*;
#(
  parameter  int CORES     = 4,
  parameter  int DATA_W    = 512,
  parameter  int CNT_W     = 6,
  parameter  int PRIO_MODE = 0,
  localparam int CH_W      = ch_w(CORES)
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [CORES-1:0]        ch_en,
  input  logic [CORES*DATA_W-1:0] ch_data,
  input  logic [CORES*CNT_W-1:0]  ch_count,
  input  logic [CORES*CNT_W-1:0]  ch_len,
  output logic [CORES-1:0]        ch_rd,
  output logic [DATA_W-1:0]       src_data,
  output logic                    src_valid,
  output logic                    src_sop,
  output logic                    src_eop,
  input  logic                    src_ready,
  output logic [CH_W-1:0]         src_channel,
  output logic                    busy,
  output logic [PKT_CNT_W-1:0]    pkt_count
);

  state_e                 state_q;
  logic [CH_W-1:0]        gnt_q;
  logic [CH_W-1:0]        rr_ptr_q;
  logic [CNT_W-1:0]       beat_rem_q;
  logic                   first_q;
  logic [DATA_W-1:0]      src_data_q;
  logic                   src_valid_q;
  logic                   src_sop_q;
  logic                   src_eop_q;
  logic [CH_W-1:0]        src_channel_q;
  logic [PKT_CNT_W-1:0]   pkt_count_q;

  logic [CORES-1:0]       w_elig;
  logic [CNT_W-1:0]       w_len [CORES];
  logic [DATA_W-1:0]      w_dat [CORES];
  logic [CH_W-1:0]        w_pick;
  logic                   w_any;
  logic [CH_W-1:0]        w_next_ptr;
  logic                   w_accept;
  logic                   w_load;

  for (genvar i = 0; i < CORES; i++) begin : g_ch
    assign w_len[i]  = ch_len[i*CNT_W +: CNT_W];
    assign w_dat[i]  = ch_data[i*DATA_W +: DATA_W];
    assign w_elig[i] = ch_en[i] & (w_len[i] != '0) & (ch_count[i*CNT_W +: CNT_W] >= w_len[i]);
  end

  mspe_rr_pick #(
    .CORES (CORES),
    .IDX_W (CH_W)
  ) u_pick (
    .req  (w_elig),
    .ptr  (rr_ptr_q),
    .mode (PRIO_MODE != 0),
    .gnt  (w_pick),
    .any  (w_any)
  );

  assign w_next_ptr = (w_pick == CH_W'(CORES - 1)) ? '0 : w_pick + 1'b1;
  assign w_accept   = src_valid_q & src_ready;
  // A beat may be loaded when the output register is empty or draining this cycle.
  assign w_load     = (state_q == XFER) & (~src_valid_q | src_ready) & (beat_rem_q != '0);

  always_comb begin
    ch_rd = '0;
    if (w_load) ch_rd[gnt_q] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      gnt_q         <= '0;
      rr_ptr_q      <= '0;
      beat_rem_q    <= '0;
      first_q       <= 1'b0;
      src_data_q    <= '0;
      src_valid_q   <= 1'b0;
      src_sop_q     <= 1'b0;
      src_eop_q     <= 1'b0;
      src_channel_q <= '0;
      pkt_count_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (w_accept) begin
            src_valid_q <= 1'b0;
            src_sop_q   <= 1'b0;
            src_eop_q   <= 1'b0;
          end
          if (w_any) begin
            gnt_q      <= w_pick;
            beat_rem_q <= w_len[w_pick];
            first_q    <= 1'b1;
            state_q    <= XFER;
            if (PRIO_MODE == 0) rr_ptr_q <= w_next_ptr;
          end
        end
        XFER: begin
          if (w_load) begin
            src_data_q    <= w_dat[gnt_q];
            src_valid_q   <= 1'b1;
            src_sop_q     <= first_q;
            src_eop_q     <= (beat_rem_q == CNT_W'(1));
            src_channel_q <= gnt_q;
            first_q       <= 1'b0;
            beat_rem_q    <= beat_rem_q - 1'b1;
            if (beat_rem_q == CNT_W'(1)) state_q <= IDLE;
          end else begin
            if (w_accept) src_valid_q <= 1'b0;
            if (beat_rem_q == '0) state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
      if (w_accept && src_eop_q) pkt_count_q <= pkt_count_q + 1'b1;
    end
  end

  assign src_data    = src_data_q;
  assign src_valid   = src_valid_q;
  assign src_sop     = src_sop_q;
  assign src_eop     = src_eop_q;
  assign src_channel = src_channel_q;
  assign busy        = (state_q == XFER);
  assign pkt_count   = pkt_count_q;

endmodule

`default_nettype wire
